// File: rtl/mseq_pkg.sv
// Shared constants and state encoding for the PN15 (x^15+x^14+1) sequence checker.
package mseq_pkg;

   localparam int LFSR_LEN = 15;
   localparam int TAP_HI   = 14;
   localparam int TAP_LO   = 13;

   localparam logic [LFSR_LEN-1:0] PN15_SEED = 15'h3BBB;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_t;

endpackage

// File: rtl/mseq_lfsr15.sv
// Local PN15 register: shifts received bits in while hunting, free-runs (flywheel) while locked.
module mseq_lfsr15
   import mseq_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                load_bit,
   input  logic                step,
   input  logic                din,
   output logic [LFSR_LEN-1:0] hist,
   output logic                expected
);

   assign expected = hist[TAP_HI] ^ hist[TAP_LO];

   // clear beats everything so a loss of lock restarts hunting from an empty history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist <= '0;
      end else if (clear) begin
         hist <= '0;
      end else if (load_bit) begin
         hist <= {hist[LFSR_LEN-2:0], din};
      end else if (step) begin
         hist <= {hist[LFSR_LEN-2:0], expected};
      end
   end

endmodule

// File: rtl/mseq_checker.sv
// PN15 receive checker: self-synchronises, flywheels, flags bit errors and loss of lock.
// Optional cumulative error counter (err_cnt, err_cnt_clr) enabled by defining MSEQ_ERRCNT_EN.
module mseq_checker
   import mseq_pkg::*;
#(
   parameter int SYNC_CNT = 32,
   parameter int WIN_LEN  = 256,
   parameter int LOSS_THR = 16
`ifdef MSEQ_ERRCNT_EN
   ,
   parameter int CNT_W    = 16
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
`ifdef MSEQ_ERRCNT_EN
   input  logic             err_cnt_clr,
   output logic [CNT_W-1:0] err_cnt,
`endif
   output logic             locked,
   output logic             err
);

   localparam int MATCH_W = $clog2(SYNC_CNT + 1);
   localparam int WIN_W   = $clog2(WIN_LEN);
   localparam int WERR_W  = $clog2(LOSS_THR + 1);
   localparam int FILL_W  = $clog2(LFSR_LEN + 1);

   state_t              state;
   logic [FILL_W-1:0]   fill;
   logic [MATCH_W-1:0]  match;
   logic [WIN_W-1:0]    win_cnt;
   logic [WERR_W-1:0]   win_err;
   logic [LFSR_LEN-1:0] hist;
   logic                expected;
   logic                mismatch;
   logic                load_bit;
   logic                step;
   logic                hunt_ok;
   logic                sync_hit;
   logic                loss;

   assign mismatch = din != expected;
   assign load_bit = din_valid && (state == HUNT);
   assign step     = din_valid && (state == LOCK);

   // an all-zero history predicts zero forever, so it must never count as a match
   assign hunt_ok  = (fill == FILL_W'(LFSR_LEN)) && (hist != '0) && !mismatch;
   assign sync_hit = load_bit && hunt_ok && (match == MATCH_W'(SYNC_CNT - 1));
   assign loss     = step && mismatch && (win_err == WERR_W'(LOSS_THR - 1));

   mseq_lfsr15 u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .clear    (loss),
      .load_bit (load_bit),
      .step     (step),
      .din      (din),
      .hist     (hist),
      .expected (expected)
   );

   // loss is tested before the window wrap so the last bit of a window can still drop lock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= HUNT;
         locked  <= 1'b0;
         err     <= 1'b0;
         fill    <= '0;
         match   <= '0;
         win_cnt <= '0;
         win_err <= '0;
      end else begin
         err <= 1'b0;
         if (din_valid) begin
            if (state == HUNT) begin
               if (fill != FILL_W'(LFSR_LEN)) begin
                  fill <= fill + FILL_W'(1);
               end
               if (sync_hit) begin
                  state   <= LOCK;
                  locked  <= 1'b1;
                  match   <= '0;
                  win_cnt <= '0;
                  win_err <= '0;
               end else if (hunt_ok) begin
                  match <= match + MATCH_W'(1);
               end else begin
                  match <= '0;
               end
            end else begin
               err <= mismatch;
               if (loss) begin
                  state  <= HUNT;
                  locked <= 1'b0;
                  fill   <= '0;
                  match  <= '0;
               end else if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
                  win_cnt <= '0;
                  win_err <= '0;
               end else begin
                  win_cnt <= win_cnt + WIN_W'(1);
                  win_err <= win_err + WERR_W'(mismatch);
               end
            end
         end
      end
   end

`ifdef MSEQ_ERRCNT_EN
   // counts err pulses; the clear wins over a same-cycle increment, and it survives loss of lock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (err_cnt_clr) begin
         err_cnt <= '0;
      end else if (err && (err_cnt != '1)) begin
         err_cnt <= err_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_mseq_checker.sv
// Self-checking bench for mseq_checker: table-driven error scenarios, directed sequences and
// randomized traffic compared against a queue-based behavioural model.
module tb_mseq_checker;
   import mseq_pkg::*;

   localparam int SYNC_CNT = 32;
   localparam int WIN_LEN  = 256;
   localparam int LOSS_THR = 16;
   localparam int CNT_MAX  = 15;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic din = 1'b0;
   logic din_valid = 1'b0;
   logic locked;
   logic err;
`ifdef MSEQ_ERRCNT_EN
   logic       err_cnt_clr = 1'b0;
   logic [3:0] err_cnt;
`endif

   int errors = 0;
   int checks = 0;
   int pulses = 0;
   bit seen_lock;
   logic [14:0] gen;

   bit m_locked;
   bit m_err;
   bit q[$];
   int m_match;
   int m_win;
   int m_werr;
   int m_cnt;

   always #5 clk = ~clk;

`ifdef MSEQ_ERRCNT_EN
   mseq_checker #(.CNT_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_valid   (din_valid),
      .err_cnt_clr (err_cnt_clr),
      .err_cnt     (err_cnt),
      .locked      (locked),
      .err         (err)
   );
`else
   mseq_checker dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .locked    (locked),
      .err       (err)
   );
`endif

   typedef struct {
      int first_idx;
      int spacing;
      int n_inv;
      bit exp_locked;
      int exp_pulses;
   } err_vec_t;

   err_vec_t vecs[6];

   // Reference PN15 generator: each output obeys x[n] = x[n-14] ^ x[n-15].
   function automatic bit genBit();
      bit b;
      b = gen[14] ^ gen[13];
      gen = {gen[13:0], b};
      return b;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
      end
   endtask

   task automatic modelReset();
      m_locked = 1'b0;
      m_err    = 1'b0;
      q.delete();
      m_match  = 0;
      m_win    = 0;
      m_werr   = 0;
      m_cnt    = 0;
   endtask

   task automatic modelStep(input bit v, input bit d, input bit clr);
      bit pred;
      bit miss;
      bit nz;
      if (clr) m_cnt = 0;
      else if (m_err && m_cnt < CNT_MAX) m_cnt++;
      m_err = 1'b0;
      if (!v) return;
      pred = (q.size() == 15) ? (q[0] ^ q[1]) : 1'b0;
      if (!m_locked) begin
         nz = 1'b0;
         foreach (q[i]) nz |= q[i];
         if (q.size() == 15 && nz && d == pred) m_match++;
         else m_match = 0;
         q.push_back(d);
         if (q.size() > 15) void'(q.pop_front());
         if (m_match == SYNC_CNT) begin
            m_locked = 1'b1;
            m_match  = 0;
            m_win    = 0;
            m_werr   = 0;
         end
      end else begin
         miss  = d != pred;
         m_err = miss;
         q.push_back(pred);
         void'(q.pop_front());
         if (miss && m_werr + 1 >= LOSS_THR) begin
            m_locked = 1'b0;
            q.delete();
            m_match = 0;
         end else if (m_win == WIN_LEN - 1) begin
            m_win  = 0;
            m_werr = 0;
         end else begin
            m_win++;
            m_werr += int'(miss);
         end
      end
   endtask

   task automatic applyStimulus(input bit v, input bit d, input bit clr);
      din_valid = v;
      din = d;
`ifdef MSEQ_ERRCNT_EN
      err_cnt_clr = clr;
`endif
      @(posedge clk);
      #1;
      modelStep(v, d, clr);
      checkOutput("locked", locked, m_locked);
      checkOutput("err", err, m_err);
`ifdef MSEQ_ERRCNT_EN
      checkOutput("err_cnt", err_cnt, m_cnt);
      err_cnt_clr = 1'b0;
`endif
      pulses += int'(err);
      seen_lock |= locked;
      din_valid = 1'b0;
   endtask

   task automatic doReset();
      rst = 1'b1;
      din_valid = 1'b0;
      #2;
      checkOutput("async_rst_locked", locked, 0);
      checkOutput("async_rst_err", err, 0);
`ifdef MSEQ_ERRCNT_EN
      checkOutput("async_rst_err_cnt", err_cnt, 0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();
      gen = PN15_SEED;
   endtask

   task automatic lockUp(input string name);
      int n;
      n = 0;
      do begin
         applyStimulus(1'b1, genBit(), 1'b0);
         n++;
      end while (!locked && n < 100);
      checkOutput(name, n, 47);
   endtask

   initial begin
      int c;
      int nv;
      int last;
      bit v;
      bit d;
      bit inv;

      vecs[0] = '{first_idx: 5,   spacing: 1,  n_inv: 1,  exp_locked: 1'b1, exp_pulses: 1};
      vecs[1] = '{first_idx: 0,   spacing: 3,  n_inv: 15, exp_locked: 1'b1, exp_pulses: 15};
      vecs[2] = '{first_idx: 0,   spacing: 3,  n_inv: 16, exp_locked: 1'b0, exp_pulses: 16};
      vecs[3] = '{first_idx: 10,  spacing: 30, n_inv: 16, exp_locked: 1'b1, exp_pulses: 16};
      vecs[4] = '{first_idx: 240, spacing: 1,  n_inv: 16, exp_locked: 1'b0, exp_pulses: 16};
      vecs[5] = '{first_idx: 241, spacing: 1,  n_inv: 16, exp_locked: 1'b1, exp_pulses: 16};

      #1;
      doReset();
      checkOutput("reset_locked", locked, 0);
      checkOutput("reset_err", err, 0);

      // Clean stream: lock on bit 47, then 10k bits without an error pulse.
      lockUp("lock_latency");
      pulses = 0;
      repeat (10000) applyStimulus(1'b1, genBit(), 1'b0);
      checkOutput("clean_10k_pulses", pulses, 0);
      checkOutput("clean_10k_locked", locked, 1);

      // Error-injection table, each entry starting from a fresh lock at window index 0.
      foreach (vecs[i]) begin
         doReset();
         lockUp($sformatf("vec%0d_lock", i));
         pulses = 0;
         last = vecs[i].first_idx + vecs[i].spacing * (vecs[i].n_inv - 1);
         for (int k = 0; k <= last; k++) begin
            inv = (k >= vecs[i].first_idx) && ((k - vecs[i].first_idx) % vecs[i].spacing == 0);
            applyStimulus(1'b1, genBit() ^ inv, 1'b0);
         end
         checkOutput($sformatf("vec%0d_locked", i), locked, vecs[i].exp_locked);
         if (vecs[i].exp_locked) repeat (40) applyStimulus(1'b1, genBit(), 1'b0);
         else lockUp($sformatf("vec%0d_relock", i));
         checkOutput($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
      end

      // All-zero input must never lock.
      doReset();
      seen_lock = 1'b0;
      pulses = 0;
      repeat (1000) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("zero_stream_locked", seen_lock, 0);
      checkOutput("zero_stream_pulses", pulses, 0);

      // Valid on every third cycle: still 47 valid bits to lock.
      doReset();
      c = 0;
      nv = 0;
      do begin
         v = (c % 3 == 0);
         d = v ? genBit() : 1'($urandom_range(0, 1));
         applyStimulus(v, d, 1'b0);
         if (v) nv++;
         c++;
      end while (!locked && c < 400);
      checkOutput("gapped_lock_valid_bits", nv, 47);
      checkOutput("gapped_lock_cycles", c, 139);

      // Reset mid-LOCK while an err pulse is showing, then relock.
      repeat (20) applyStimulus(1'b1, genBit(), 1'b0);
      applyStimulus(1'b1, ~genBit(), 1'b0);
      checkOutput("pre_rst_err", err, 1);
      doReset();
      lockUp("relock_after_rst");

`ifdef MSEQ_ERRCNT_EN
      // Saturation of a 4-bit counter, then clear concurrent with an err pulse.
      for (int k = 0; k < 400; k++) applyStimulus(1'b1, genBit() ^ (k % 20 == 0), 1'b0);
      checkOutput("err_cnt_saturated", err_cnt, CNT_MAX);
      applyStimulus(1'b1, ~genBit(), 1'b0);
      applyStimulus(1'b1, genBit(), 1'b1);
      checkOutput("err_cnt_clr_wins", err_cnt, 0);
`endif

      // Randomized traffic with periodic high-error bursts and occasional resets.
      doReset();
      for (int k = 0; k < 6000; k++) begin
         if ($urandom_range(0, 999) == 0) doReset();
         if (k % 2000 < 300) inv = ($urandom_range(0, 3) == 0);
         else inv = ($urandom_range(0, 49) == 0);
         v = 1'($urandom_range(0, 1));
         d = v ? (genBit() ^ inv) : 1'($urandom_range(0, 1));
         applyStimulus(v, d, $urandom_range(0, 199) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
